// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku datapath: FSM state encoding and the
// board-geometry width helpers used by the board controller, the board
// generator and the user-input front end.
package sudoku_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CELL  = 3'd1,
    ST_VAL   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Smallest width w with 2**w >= value (0 for value <= 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) width = i + 1;
    end
    return width;
  endfunction

  // N: symbols per row/column/box.
  function automatic int unsigned num_vals(input int unsigned box);
    return box * box;
  endfunction

  // CELLS: cells on the board.
  function automatic int unsigned num_cells(input int unsigned box);
    return num_vals(box) * num_vals(box);
  endfunction

  // VW: bits per cell value (0..N).
  function automatic int unsigned val_width(input int unsigned box);
    return clog2(num_vals(box) + 1);
  endfunction

  // CW: bits per cell index.
  function automatic int unsigned cell_width(input int unsigned box);
    return clog2(num_cells(box));
  endfunction

  // DW: shared index/value entry bus width.
  function automatic int unsigned data_width(input int unsigned box);
    return (cell_width(box) > val_width(box)) ? cell_width(box) : val_width(box);
  endfunction

endpackage

// File: rtl/sudoku_check_scan.sv
// Sequential solution compare: walks the board one cell per cycle while
// en_i is high and accumulates the number of cells differing from the
// reference solution.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   start_i        clears index and accumulator (cycle before scanning)
//   en_i           scan one cell this cycle
//   board_i        current board, cell i at [i*VW +: VW]
//   solution_i     reference solution, same packing
//   done_o         high while the last cell is being compared
//   total_o        mismatch total including the cell compared this cycle
module sudoku_check_scan
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX   = 2,
  localparam int unsigned CELLS = num_cells(BOX),
  localparam int unsigned VW    = val_width(BOX),
  localparam int unsigned CW    = cell_width(BOX)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                en_i,
  input  logic [CELLS*VW-1:0] board_i,
  input  logic [CELLS*VW-1:0] solution_i,
  output logic                done_o,
  output logic [CW:0]         total_o
);

  localparam logic [CW-1:0] LAST_IDX = CW'(CELLS - 1);

  logic [CW-1:0] idx_q, idx_d;
  logic [CW:0]   acc_q, acc_d;
  logic          cell_mismatch;

  // Kept apart from the next-state block so done_o has no path from start_i.
  assign cell_mismatch = board_i[idx_q*VW +: VW] != solution_i[idx_q*VW +: VW];
  assign total_o       = acc_q + (CW+1)'(cell_mismatch);
  assign done_o        = en_i && (idx_q == LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (start_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (en_i) begin
      idx_d = done_o ? '0 : idx_q + CW'(1);
      acc_d = total_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/sudoku_board_ctrl.sv
// Board-entry and solution-check controller for a BOX x BOX-box Sudoku.
// Loads givens (which become write-protected), takes cell-index/value pairs
// on a shared entry bus, and once the board is full runs a one-cell-per-cycle
// compare against the reference solution.
//   in_clk, in_restart_n  clock, asynchronous active-low reset
//   in_load               load pulse (beats everything else)
//   in_givens             puzzle givens, cell i at [i*VW +: VW], 0 = empty
//   in_solution           reference solution, same packing
//   in_enter              qualifies in_diff_cell_val
//   in_diff_cell_val      cell index in CELL, value in VAL
//   out_state             IDLE=0 CELL=1 VAL=2 CHECK=3 DONE=4
//   out_user_board        current board
//   out_fill_flag         per-cell non-empty flag
//   out_fill_count        number of non-empty cells
//   out_err               one-cycle pulse after a rejected entry
//   out_mismatch          mismatch count of the last completed check
//   out_solved            high in DONE
module sudoku_board_ctrl
  import sudoku_pkg::*;
#(
  parameter  int unsigned BOX   = 2,
  localparam int unsigned N     = num_vals(BOX),
  localparam int unsigned CELLS = num_cells(BOX),
  localparam int unsigned VW    = val_width(BOX),
  localparam int unsigned CW    = cell_width(BOX),
  localparam int unsigned DW    = data_width(BOX)
) (
  input  logic                in_clk,
  input  logic                in_restart_n,
  input  logic                in_load,
  input  logic [CELLS*VW-1:0] in_givens,
  input  logic [CELLS*VW-1:0] in_solution,
  input  logic                in_enter,
  input  logic [DW-1:0]       in_diff_cell_val,
  output logic [2:0]          out_state,
  output logic [CELLS*VW-1:0] out_user_board,
  output logic [CELLS-1:0]    out_fill_flag,
  output logic [CW:0]         out_fill_count,
  output logic                out_err,
  output logic [CW:0]         out_mismatch,
  output logic                out_solved
);

  localparam logic [DW:0]   CELLS_X = (DW+1)'(CELLS);
  localparam logic [DW-1:0] N_X     = DW'(N);
  localparam logic [CW:0]   FULL    = (CW+1)'(CELLS);

  state_e                   state_q, state_d;
  logic [CELLS-1:0][VW-1:0] board_q, board_d;
  logic [CELLS-1:0]         fixed_q, fixed_d;
  logic [CELLS-1:0]         flag_q, flag_d;
  logic [CW:0]              count_q, count_d;
  logic [CW:0]              mismatch_q, mismatch_d;
  logic [CW-1:0]            sel_q, sel_d;
  logic                     err_q, err_d;
  logic                     solved_q;

  logic [CW-1:0]            idx_c;
  logic                     idx_ok, cell_open, val_ok, new_filled;
  logic                     scan_start, scan_en, scan_done;
  logic [CW:0]              scan_total;

  assign idx_c      = in_diff_cell_val[CW-1:0];
  assign idx_ok     = {1'b0, in_diff_cell_val} < CELLS_X;
  // fixed_q is only meaningful for in-range indices; idx_ok gates it.
  assign cell_open  = idx_ok && !fixed_q[idx_c];
  assign val_ok     = in_diff_cell_val <= N_X;
  assign new_filled = |in_diff_cell_val;

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    fixed_d    = fixed_q;
    flag_d     = flag_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;
    sel_d      = sel_q;
    err_d      = 1'b0;

    if (in_load) begin
      board_d = in_givens;
      count_d = '0;
      for (int unsigned i = 0; i < CELLS; i++) begin
        flag_d[i] = |in_givens[i*VW +: VW];
        count_d   = count_d + (CW+1)'(flag_d[i]);
      end
      fixed_d    = flag_d;
      mismatch_d = '0;
      state_d    = ST_CELL;
    end else begin
      case (state_q)
        ST_CELL: begin
          if (in_enter) begin
            if (cell_open) begin
              sel_d   = idx_c;
              state_d = ST_VAL;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_VAL: begin
          if (in_enter) begin
            if (!val_ok) begin
              err_d = 1'b1;
            end else begin
              board_d[sel_q] = in_diff_cell_val[VW-1:0];
              flag_d[sel_q]  = new_filled;
              count_d        = count_q + (CW+1)'(new_filled) - (CW+1)'(flag_q[sel_q]);
              state_d        = (count_d == FULL) ? ST_CHECK : ST_CELL;
            end
          end
        end
        ST_CHECK: begin
          if (scan_done) begin
            mismatch_d = scan_total;
            state_d    = (scan_total == '0) ? ST_DONE : ST_CELL;
          end
        end
        default: ;
      endcase
    end
  end

  // Scanner is re-armed on the write that enters CHECK so the first CHECK
  // cycle always compares cell 0, even after an aborted scan.
  assign scan_en    = state_q == ST_CHECK;
  assign scan_start = (state_d == ST_CHECK) && (state_q != ST_CHECK);

  sudoku_check_scan #(
    .BOX(BOX)
  ) u_scan (
    .clk_i     (in_clk),
    .rst_ni    (in_restart_n),
    .start_i   (scan_start),
    .en_i      (scan_en),
    .board_i   (board_q),
    .solution_i(in_solution),
    .done_o    (scan_done),
    .total_o   (scan_total)
  );

  always_ff @(posedge in_clk or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state_q    <= ST_IDLE;
      board_q    <= '0;
      fixed_q    <= '0;
      flag_q     <= '0;
      count_q    <= '0;
      mismatch_q <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      solved_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      fixed_q    <= fixed_d;
      flag_q     <= flag_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      solved_q   <= state_d == ST_DONE;
    end
  end

  assign out_state      = state_q;
  assign out_user_board = board_q;
  assign out_fill_flag  = flag_q;
  assign out_fill_count = count_q;
  assign out_err        = err_q;
  assign out_mismatch   = mismatch_q;
  assign out_solved     = solved_q;

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
module tb_sudoku_board_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, load, enter;
  logic [323:0] givens, solution;
  logic [6:0]   dval;
  int           box, n, cells, vw, dw;
  int           n_checks = 0;
  int           n_fail = 0;

  // Reference model state (transaction level)
  int m_board[81], m_fixed[81], m_sol[81], m_giv[81];
  int m_state, m_mm, m_sel, m_err;

  logic [2:0]   st2, st3;
  logic [47:0]  ub2;
  logic [15:0]  ff2;
  logic [4:0]   fc2, mm2;
  logic         er2, sv2;
  logic [323:0] ub3;
  logic [80:0]  ff3;
  logic [7:0]   fc3, mm3;
  logic         er3, sv3;

  sudoku_board_ctrl #(.BOX(2)) dut2 (
    .in_clk(clk), .in_restart_n(rst_n), .in_load(load && box == 2),
    .in_givens(givens[47:0]), .in_solution(solution[47:0]),
    .in_enter(enter && box == 2), .in_diff_cell_val(dval[3:0]),
    .out_state(st2), .out_user_board(ub2), .out_fill_flag(ff2),
    .out_fill_count(fc2), .out_err(er2), .out_mismatch(mm2), .out_solved(sv2));

  sudoku_board_ctrl #(.BOX(3)) dut3 (
    .in_clk(clk), .in_restart_n(rst_n), .in_load(load && box == 3),
    .in_givens(givens), .in_solution(solution),
    .in_enter(enter && box == 3), .in_diff_cell_val(dval),
    .out_state(st3), .out_user_board(ub3), .out_fill_flag(ff3),
    .out_fill_count(fc3), .out_err(er3), .out_mismatch(mm3), .out_solved(sv3));

  logic [2:0]   o_state;
  logic [323:0] o_board;
  logic [80:0]  o_flags;
  logic [7:0]   o_count, o_mm;
  logic         o_err, o_solved;

  always_comb begin
    o_board = '0; o_flags = '0; o_count = '0; o_mm = '0;
    if (box == 2) begin
      o_state = st2; o_board[47:0] = ub2; o_flags[15:0] = ff2;
      o_count[4:0] = fc2; o_mm[4:0] = mm2; o_err = er2; o_solved = sv2;
    end else begin
      o_state = st3; o_board = ub3; o_flags = ff3;
      o_count = fc3; o_mm = mm3; o_err = er3; o_solved = sv3;
    end
  end

  // ---------------- reference model ----------------
  function automatic void set_box(input int b);
    int cw;
    box = b; n = b * b; cells = n * n;
    vw = $clog2(n + 1); cw = $clog2(cells);
    dw = (cw > vw) ? cw : vw;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < cells; i++) if (m_board[i] != 0) c++;
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 81; i++) begin m_board[i] = 0; m_fixed[i] = 0; end
    m_state = 0; m_mm = 0; m_sel = 0; m_err = 0;
  endfunction

  function automatic void model_load();
    for (int i = 0; i < cells; i++) begin
      m_board[i] = m_giv[i]; m_fixed[i] = (m_giv[i] != 0) ? 1 : 0;
    end
    m_mm = 0; m_state = 1; m_err = 0;
  endfunction

  // The entry bus is only dw bits wide, so the model sees the truncated value.
  function automatic void model_enter(input int raw);
    int v = raw % (1 << dw);
    m_err = 0;
    case (m_state)
      1: if (v < cells && m_fixed[v] == 0) begin m_sel = v; m_state = 2; end
         else m_err = 1;
      2: if (v > n) m_err = 1;
         else begin
           m_board[m_sel] = v;
           m_state = (model_count() == cells) ? 3 : 1;
         end
      default: ;
    endcase
  endfunction

  function automatic void model_check_done();
    int mm = 0;
    for (int i = 0; i < cells; i++) if (m_board[i] != m_sol[i]) mm++;
    m_mm = mm; m_state = (mm == 0) ? 4 : 1;
  endfunction

  function automatic logic [323:0] exp_board();
    logic [323:0] r = '0;
    for (int i = 0; i < cells; i++) r = r | (324'(m_board[i]) << (i * vw));
    return r;
  endfunction

  function automatic logic [80:0] exp_flags();
    logic [80:0] r = '0;
    for (int i = 0; i < cells; i++) r[i] = (m_board[i] != 0);
    return r;
  endfunction

  function automatic int cell_of(input int i);
    return int'((o_board >> (i * vw)) & ((324'(1) << vw) - 324'(1)));
  endfunction

  function automatic void pack_inputs();
    givens = '0; solution = '0;
    for (int i = 0; i < cells; i++) begin
      givens   = givens   | (324'(m_giv[i]) << (i * vw));
      solution = solution | (324'(m_sol[i]) << (i * vw));
    end
  endfunction

  function automatic int pick_empty();
    int e[81];
    int m = 0;
    for (int i = 0; i < cells; i++) if (m_board[i] == 0) begin e[m] = i; m++; end
    return e[$urandom_range(m - 1, 0)];
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic pulse_enter(input int v);
    dval = 7'(v); enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    model_load();
  endtask

  task automatic wait_check(output int cyc);
    cyc = 0;
    while (o_state == 3'd3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Fills every empty cell in random order; cell `wrong` gets a wrong value.
  task automatic fill_rest(input int wrong);
    int order[81];
    int m = 0;
    int j, t, c, val;
    for (int i = 0; i < cells; i++) if (m_board[i] == 0) begin order[m] = i; m++; end
    for (int i = m - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int k = 0; k < m; k++) begin
      c = order[k];
      val = (c == wrong) ? (m_sol[c] % n) + 1 : m_sol[c];
      pulse_enter(c);   model_enter(c);
      pulse_enter(val); model_enter(val);
      n_checks++;
      if (o_board !== exp_board() || o_count !== 8'(model_count()) || o_err !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_write cell %0d: board %h count %0d err %b, expected board %h count %0d err 0",
                 c, o_board, o_count, o_err, exp_board(), model_count());
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_checks++;
    if (o_state !== 3'd0 || st3 !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d expected 0/0", o_state, st3);
    end
    n_checks++;
    if (o_board !== '0 || o_flags !== '0 || o_count !== '0) begin
      n_fail++; $display("FAIL reset_board: board %h flags %h count %0d expected all 0", o_board, o_flags, o_count);
    end
    n_checks++;
    if (o_mm !== '0 || o_err !== 1'b0 || o_solved !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: mm %0d err %b solved %b expected 0", o_mm, o_err, o_solved);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    pulse_enter(3); model_enter(3);
    n_checks++;
    if (o_state !== 3'(m_state) || o_err !== 1'(m_err)) begin
      n_fail++; $display("FAIL idle_ignore: state %0d err %b expected %0d %0d", o_state, o_err, m_state, m_err);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < 81; i++) m_giv[i] = 0;
    m_giv[0] = 1; m_giv[5] = 4; m_giv[10] = 2; m_giv[15] = 3;
    for (int i = 0; i < cells; i++) m_sol[i] = (m_giv[i] != 0) ? m_giv[i] : $urandom_range(n, 1);
    pack_inputs();
    pulse_load();
    n_checks++;
    if (o_count !== 8'd4 || o_state !== 3'd1) begin
      n_fail++; $display("FAIL load_count_state: count %0d state %0d expected 4 1", o_count, o_state);
    end
    n_checks++;
    if (o_flags[15:0] !== 16'h8421 || o_board !== exp_board()) begin
      n_fail++; $display("FAIL load_board: flags %h board %h expected 8421 %h", o_flags[15:0], o_board, exp_board());
    end
  endtask

  task automatic test_reject();
    int seq[5] = '{5, 16, 1, 5, 3};  // 16 truncates to fixed cell 0 on the 4-bit bus
    for (int k = 0; k < 5; k++) begin
      pulse_enter(seq[k]); model_enter(seq[k]);
      n_checks++;
      if (o_err !== 1'(m_err) || o_state !== 3'(m_state)) begin
        n_fail++; $display("FAIL reject_step%0d: err %b state %0d expected %0d %0d", k, o_err, o_state, m_err, m_state);
      end
    end
    n_checks++;
    if (cell_of(1) !== 3 || o_count !== 8'(model_count()) || o_count !== 8'd5) begin
      n_fail++; $display("FAIL reject_write: cell1 %0d count %0d expected 3 5", cell_of(1), o_count);
    end
  endtask

  task automatic test_clear();
    pulse_enter(1); model_enter(1);
    pulse_enter(0); model_enter(0);
    n_checks++;
    if (cell_of(1) !== 0 || o_flags[1] !== 1'b0 || o_count !== 8'd4 || o_flags !== exp_flags()) begin
      n_fail++; $display("FAIL clear: cell1 %0d flag1 %b count %0d expected 0 0 4", cell_of(1), o_flags[1], o_count);
    end
  endtask

  task automatic test_check();
    int w, cyc;
    w = pick_empty();
    fill_rest(w);
    n_checks++;
    if (o_state !== 3'd3) begin n_fail++; $display("FAIL check_enter: state %0d expected 3", o_state); end
    wait_check(cyc); model_check_done();
    n_checks++;
    if (cyc !== cells) begin n_fail++; $display("FAIL check_latency: %0d cycles expected %0d", cyc, cells); end
    n_checks++;
    if (o_mm !== 8'(m_mm) || o_mm !== 8'd1 || o_state !== 3'(m_state) || o_solved !== 1'b0) begin
      n_fail++; $display("FAIL check_mismatch: mm %0d state %0d solved %b expected %0d %0d 0", o_mm, o_state, o_solved, m_mm, m_state);
    end
    pulse_enter(w); model_enter(w);
    pulse_enter(m_sol[w]); model_enter(m_sol[w]);
    wait_check(cyc); model_check_done();
    n_checks++;
    if (cyc !== cells || o_state !== 3'(m_state) || o_state !== 3'd4) begin
      n_fail++; $display("FAIL check_solve: %0d cycles state %0d expected %0d 4", cyc, o_state, cells);
    end
    n_checks++;
    if (o_solved !== 1'b1 || o_mm !== 8'd0) begin
      n_fail++; $display("FAIL check_solved: solved %b mm %0d expected 1 0", o_solved, o_mm);
    end
    pulse_enter(w); model_enter(w);
    pulse_enter(0); model_enter(0);
    n_checks++;
    if (o_state !== 3'd4 || o_board !== exp_board() || o_err !== 1'b0 || o_solved !== 1'b1) begin
      n_fail++; $display("FAIL done_frozen: state %0d err %b board %h expected 4 0 %h", o_state, o_err, o_board, exp_board());
    end
  endtask

  task automatic test_async_reset();
    int w, cyc;
    pulse_load();
    w = pick_empty();
    fill_rest(w);
    wait_check(cyc); model_check_done();
    pulse_enter(w); model_enter(w);
    pulse_enter(m_sol[w]); model_enter(m_sol[w]);
    repeat (5) @(negedge clk);
    n_checks++;
    if (o_state !== 3'd3 || o_mm !== 8'd1) begin
      n_fail++; $display("FAIL pre_reset: state %0d mm %0d expected 3 1", o_state, o_mm);
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    n_checks++;
    if (o_state !== 3'(m_state) || o_board !== exp_board() || o_flags !== exp_flags() || o_count !== 8'd0) begin
      n_fail++; $display("FAIL async_reset_board: state %0d board %h count %0d expected 0", o_state, o_board, o_count);
    end
    n_checks++;
    if (o_mm !== 8'(m_mm) || o_solved !== 1'b0 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_status: mm %0d solved %b err %b expected 0", o_mm, o_solved, o_err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_abort();
    int cyc;
    pulse_load();
    fill_rest(-1);
    repeat (3) @(negedge clk);
    pulse_load();
    n_checks++;
    if (o_state !== 3'd1 || o_mm !== 8'd0 || o_count !== 8'(model_count()) || o_board !== exp_board()) begin
      n_fail++; $display("FAIL load_abort: state %0d mm %0d count %0d expected 1 0 %0d", o_state, o_mm, o_count, model_count());
    end
    fill_rest(-1);
    wait_check(cyc); model_check_done();
    n_checks++;
    if (cyc !== cells || o_state !== 3'(m_state) || o_mm !== 8'(m_mm)) begin
      n_fail++; $display("FAIL rescan: %0d cycles state %0d mm %0d expected %0d %0d %0d", cyc, o_state, o_mm, cells, m_state, m_mm);
    end
  endtask

  task automatic test_load_with_enter();
    pulse_load();
    pulse_enter(1); model_enter(1);
    n_checks++;
    if (o_state !== 3'd2) begin n_fail++; $display("FAIL load_enter_setup: state %0d expected 2", o_state); end
    load = 1'b1; enter = 1'b1; dval = 7'd3;
    @(negedge clk);
    load = 1'b0; enter = 1'b0;
    model_load();
    n_checks++;
    if (o_state !== 3'd1 || o_board !== exp_board() || o_count !== 8'(model_count()) || o_err !== 1'b0) begin
      n_fail++; $display("FAIL load_beats_enter: state %0d board %h err %b expected 1 %h 0", o_state, o_board, o_err, exp_board());
    end
  endtask

  task automatic test_box3();
    int c, cyc;
    set_box(3);
    model_reset();
    for (int r = 0; r < 9; r++)
      for (int k = 0; k < 9; k++) m_sol[r*9 + k] = ((r * 3 + r / 3 + k) % 9) + 1;
    for (int i = 0; i < 81; i++) m_giv[i] = ($urandom_range(2, 0) == 0) ? m_sol[i] : 0;
    m_giv[40] = 0;
    pack_inputs();
    pulse_load();
    n_checks++;
    if (o_state !== 3'd1 || o_count !== 8'(model_count()) || o_board !== exp_board() || o_flags !== exp_flags()) begin
      n_fail++; $display("FAIL b3_load: state %0d count %0d expected 1 %0d", o_state, o_count, model_count());
    end
    c = pick_empty();
    pulse_enter(c); model_enter(c);
    pulse_enter(10); model_enter(10);
    n_checks++;
    if (o_err !== 1'b1 || o_state !== 3'(m_state) || o_state !== 3'd2) begin
      n_fail++; $display("FAIL b3_value10: err %b state %0d expected 1 2", o_err, o_state);
    end
    pulse_enter(m_sol[c]); model_enter(m_sol[c]);
    fill_rest(-1);
    wait_check(cyc); model_check_done();
    n_checks++;
    if (cyc !== 81) begin n_fail++; $display("FAIL b3_latency: %0d cycles expected 81", cyc); end
    n_checks++;
    if (o_state !== 3'(m_state) || o_solved !== 1'b1 || o_mm !== 8'd0) begin
      n_fail++; $display("FAIL b3_solved: state %0d solved %b mm %0d expected %0d 1 0", o_state, o_solved, o_mm, m_state);
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; enter = 1'b0; dval = '0;
    givens = '0; solution = '0;
    set_box(2);
    model_reset();
    test_reset();
    test_load();
    test_reject();
    test_clear();
    test_check();
    test_async_reset();
    test_load_abort();
    test_load_with_enter();
    test_box3();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
